// File: rtl/uart_rx_pkg.sv
// uart_rx_pkg
// Shared definitions for the UART receive controller:
//   - rx_state_e : receive FSM state encoding
//   - PRESCALE_* : legal oversampling ratios; anything else is treated as 8
//   - PAR_EVEN / PAR_ODD : values of the PAR_TYP configuration input
//   - parity_bit() : parity bit a transmitter would send for a given data word
package uart_rx_pkg;

    typedef enum logic [2:0] {
        IDLE   = 3'b000,
        START  = 3'b001,
        DATA   = 3'b010,
        PARITY = 3'b011,
        STOP   = 3'b100
    } rx_state_e;

    localparam int PRESCALE_8  = 8;
    localparam int PRESCALE_16 = 16;
    localparam int PRESCALE_32 = 32;

    localparam logic PAR_EVEN = 1'b0;
    localparam logic PAR_ODD  = 1'b1;

    // data_xor is the XOR reduction of the data word; odd parity inverts it
    function automatic logic parity_bit(input logic par_typ, input logic data_xor);
        return (par_typ == PAR_ODD) ? ~data_xor : data_xor;
    endfunction

endpackage

// File: rtl/uart_rx_if.sv
// uart_rx_if
// Bundles the serial line, frame configuration and received-data outputs.
//   RX_IN      : serial line, idle high, already synchronous to CLK
//   Prescale   : oversampling ratio (8, 16 or 32)
//   PAR_EN     : parity bit present after the data bits
//   PAR_TYP    : 0 = even parity, 1 = odd parity
//   P_DATA     : last good received byte
//   data_valid : one-cycle pulse, good frame
//   par_err    : one-cycle pulse, parity mismatch
//   stp_err    : one-cycle pulse, stop bit sampled low
//   busy       : a frame is in progress
// master = line/configuration side, slave = the receiver.
interface uart_rx_if #(
    parameter int DATA_LENGTH = 8,
    parameter int PRESCALE_W  = 6
);
    logic                   RX_IN;
    logic [PRESCALE_W-1:0]  Prescale;
    logic                   PAR_EN;
    logic                   PAR_TYP;
    logic [DATA_LENGTH-1:0] P_DATA;
    logic                   data_valid;
    logic                   par_err;
    logic                   stp_err;
    logic                   busy;

    modport master (
        output RX_IN, Prescale, PAR_EN, PAR_TYP,
        input  P_DATA, data_valid, par_err, stp_err, busy
    );

    modport slave (
        input  RX_IN, Prescale, PAR_EN, PAR_TYP,
        output P_DATA, data_valid, par_err, stp_err, busy
    );
endinterface

// File: rtl/uart_rx_sampler.sv
// uart_rx_sampler
// Oversampling counter and 3-point majority voter for one bit period.
//   CLK, RST   : clock and synchronous active-high reset
//   clear      : start edge seen this cycle; next cycle is edge index 1
//   enable     : a frame is in progress
//   rx_in      : serial line
//   prescale   : latched oversampling ratio for this frame
//   bit_value  : majority of the samples taken at H-1, H, H+1
//   bit_done   : current cycle is edge index prescale-1
//   stop_done  : current cycle is edge index H+2 (early stop decision)
module uart_rx_sampler #(
    parameter int PRESCALE_W = 6
) (
    input  logic                  CLK,
    input  logic                  RST,
    input  logic                  clear,
    input  logic                  enable,
    input  logic                  rx_in,
    input  logic [PRESCALE_W-1:0] prescale,
    output logic                  bit_value,
    output logic                  bit_done,
    output logic                  stop_done
);
    logic [PRESCALE_W-1:0] edge_cnt;
    logic [PRESCALE_W-1:0] half;
    logic [PRESCALE_W-1:0] last_edge;
    logic [2:0]            samples;

    assign half      = prescale >> 1;
    assign last_edge = prescale - PRESCALE_W'(1);

    // The detection cycle itself is edge index 0, so clear loads 1.
    always_ff @(posedge CLK) begin
        if (RST) begin
            edge_cnt <= '0;
            samples  <= '0;
        end else if (clear) begin
            edge_cnt <= PRESCALE_W'(1);
            samples  <= '0;
        end else if (enable) begin
            edge_cnt <= (edge_cnt == last_edge) ? '0 : edge_cnt + PRESCALE_W'(1);
            if (edge_cnt == half - PRESCALE_W'(1)) samples[0] <= rx_in;
            if (edge_cnt == half)                  samples[1] <= rx_in;
            if (edge_cnt == half + PRESCALE_W'(1)) samples[2] <= rx_in;
        end else begin
            edge_cnt <= '0;
        end
    end

    assign bit_value = (samples[0] & samples[1]) | (samples[0] & samples[2]) |
                       (samples[1] & samples[2]);
    assign bit_done  = enable && (edge_cnt == last_edge);
    assign stop_done = enable && (edge_cnt == half + PRESCALE_W'(2));

endmodule

// File: rtl/uart_rx_fsm.sv
// uart_rx_fsm
// UART receive controller: start detection, data shift-in (LSB first),
// optional parity check, stop check, and registered result pulses.
//   CLK    : system clock, rising edge
//   RST    : synchronous active-high reset; a partial frame is discarded
//   rx_bus : uart_rx_if slave (line, configuration, results)
// DATA_LENGTH must be at least 2.
module uart_rx_fsm
    import uart_rx_pkg::*;
#(
    parameter int DATA_LENGTH = 8,
    parameter int PRESCALE_W  = 6
) (
    input  logic     CLK,
    input  logic     RST,
    uart_rx_if.slave rx_bus
);
    localparam int CNT_W = (DATA_LENGTH > 1) ? $clog2(DATA_LENGTH) : 1;

    rx_state_e              state;
    rx_state_e              state_next;
    logic                   start_det;
    logic [PRESCALE_W-1:0]  prescale_norm;
    logic [PRESCALE_W-1:0]  prescale_q;
    logic                   par_en_q;
    logic                   par_typ_q;
    logic                   par_bad;
    logic [CNT_W-1:0]       bit_cnt;
    logic                   last_bit;
    logic [DATA_LENGTH-1:0] shift_reg;
    logic [DATA_LENGTH-1:0] p_data_q;
    logic                   data_valid_q;
    logic                   par_err_q;
    logic                   stp_err_q;
    logic                   bit_value;
    logic                   bit_done;
    logic                   stop_done;

    uart_rx_sampler #(.PRESCALE_W(PRESCALE_W)) u_sampler (
        .CLK       (CLK),
        .RST       (RST),
        .clear     (start_det),
        .enable    (state != IDLE),
        .rx_in     (rx_bus.RX_IN),
        .prescale  (prescale_q),
        .bit_value (bit_value),
        .bit_done  (bit_done),
        .stop_done (stop_done)
    );

    // Unsupported ratios fall back to 8
    always_comb begin
        prescale_norm = PRESCALE_W'(PRESCALE_8);
        if (rx_bus.Prescale == PRESCALE_W'(PRESCALE_16) ||
            rx_bus.Prescale == PRESCALE_W'(PRESCALE_32)) begin
            prescale_norm = rx_bus.Prescale;
        end
    end

    assign last_bit = (bit_cnt == CNT_W'(DATA_LENGTH - 1));

    always_ff @(posedge CLK) begin
        if (RST) state <= IDLE;
        else     state <= state_next;
    end

    // The stop decision is taken mid-bit so the receiver is back in IDLE
    // early enough to catch a start edge that follows without idle time.
    always_comb begin
        state_next = state;
        start_det  = 1'b0;
        case (state)
            IDLE: begin
                if (!rx_bus.RX_IN) begin
                    start_det  = 1'b1;
                    state_next = START;
                end
            end
            START: begin
                if (bit_done) state_next = bit_value ? IDLE : DATA;
            end
            DATA: begin
                if (bit_done && last_bit) state_next = par_en_q ? PARITY : STOP;
            end
            PARITY: begin
                if (bit_done) state_next = STOP;
            end
            STOP: begin
                if (stop_done) state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    // Configuration latch, data shifting, parity check and result pulses.
    // The pulses land in the cycle after the stop decision, i.e. the first
    // IDLE cycle.
    always_ff @(posedge CLK) begin
        if (RST) begin
            prescale_q   <= PRESCALE_W'(PRESCALE_8);
            par_en_q     <= 1'b0;
            par_typ_q    <= PAR_EVEN;
            par_bad      <= 1'b0;
            bit_cnt      <= '0;
            shift_reg    <= '0;
            p_data_q     <= '0;
            data_valid_q <= 1'b0;
            par_err_q    <= 1'b0;
            stp_err_q    <= 1'b0;
        end else begin
            data_valid_q <= 1'b0;
            par_err_q    <= 1'b0;
            stp_err_q    <= 1'b0;
            if (start_det) begin
                prescale_q <= prescale_norm;
                par_en_q   <= rx_bus.PAR_EN;
                par_typ_q  <= rx_bus.PAR_TYP;
                par_bad    <= 1'b0;
                bit_cnt    <= '0;
            end
            case (state)
                DATA: begin
                    if (bit_done) begin
                        shift_reg <= {bit_value, shift_reg[DATA_LENGTH-1:1]};
                        bit_cnt   <= bit_cnt + CNT_W'(1);
                    end
                end
                PARITY: begin
                    if (bit_done) par_bad <= (bit_value != parity_bit(par_typ_q, ^shift_reg));
                end
                STOP: begin
                    if (stop_done) begin
                        par_err_q <= par_bad;
                        stp_err_q <= ~bit_value;
                        if (!par_bad && bit_value) begin
                            data_valid_q <= 1'b1;
                            p_data_q     <= shift_reg;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    assign rx_bus.P_DATA     = p_data_q;
    assign rx_bus.data_valid = data_valid_q;
    assign rx_bus.par_err    = par_err_q;
    assign rx_bus.stp_err    = stp_err_q;
    assign rx_bus.busy       = (state != IDLE);

endmodule

// File: tb/tb_uart_rx_fsm.sv
// tb_uart_rx_fsm
// Directed bench for uart_rx_fsm: drives whole frames onto RX_IN and checks
// pulse timing, received data and error flags against hand-computed values.
module tb_uart_rx_fsm;
    import uart_rx_pkg::*;

    localparam int DL = 8;
    localparam int PW = 6;

    logic CLK = 1'b0;
    logic RST;

    always #5 CLK = ~CLK;

    uart_rx_if #(.DATA_LENGTH(DL), .PRESCALE_W(PW)) rx_bus ();

    uart_rx_fsm #(.DATA_LENGTH(DL), .PRESCALE_W(PW)) dut (
        .CLK    (CLK),
        .RST    (RST),
        .rx_bus (rx_bus)
    );

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;
    int start_cyc;

    int         dv_count, pe_count, se_count;
    int         pe_cycle, se_cycle;
    int         busy_first, busy_last, busy_cnt;
    int         dv_cycles[$];
    logic [7:0] dv_data[$];

    always @(posedge CLK) cyc <= cyc + 1;

    // Event recorder, sampled mid-cycle
    always @(negedge CLK) begin
        if (rx_bus.data_valid) begin
            dv_count++;
            dv_cycles.push_back(cyc);
            dv_data.push_back(rx_bus.P_DATA);
        end
        if (rx_bus.par_err) begin
            pe_count++;
            pe_cycle = cyc;
        end
        if (rx_bus.stp_err) begin
            se_count++;
            se_cycle = cyc;
        end
        if (rx_bus.busy) begin
            busy_cnt++;
            busy_last = cyc;
            if (busy_first < 0) busy_first = cyc;
        end
    end

    initial begin
        #1_000_000;
        $display("[TB] FAIL watchdog got=timeout exp=finish");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("[TB] FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
        end
    endtask

    task automatic clearMonitor();
        dv_count   = 0;
        pe_count   = 0;
        se_count   = 0;
        pe_cycle   = -1;
        se_cycle   = -1;
        busy_first = -1;
        busy_last  = -1;
        busy_cnt   = 0;
        dv_cycles.delete();
        dv_data.delete();
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge CLK);
        #1;
    endtask

    // Drives one frame; start_cyc marks the detection cycle. stop_len is the
    // stop-bit length in cycles, corrupt_bit flips the H-1 sample of that data
    // bit, abort_after (>=0) stops driving after that many cycles.
    task automatic applyStimulus(input logic [7:0] data, input int pre, input bit par_en,
                                 input bit par_typ, input bit par_bit, input bit stop_bit,
                                 input int stop_len, input int corrupt_bit, input int abort_after);
        int   total;
        int   idx;
        int   j;
        logic v;
        total = (par_en ? 10 : 9) * pre + stop_len;
        if (abort_after >= 0 && abort_after < total) total = abort_after;
        rx_bus.Prescale = PW'(pre);
        rx_bus.PAR_EN   = par_en;
        rx_bus.PAR_TYP  = par_typ;
        start_cyc       = cyc;
        for (int c = 0; c < total; c++) begin
            idx = c / pre;
            j   = c % pre;
            if (idx == 0)                 v = 1'b0;
            else if (idx <= 8)            v = data[idx-1];
            else if (par_en && idx == 9)  v = par_bit;
            else                          v = stop_bit;
            if (corrupt_bit >= 0 && idx == corrupt_bit + 1 && j == pre / 2 - 1) v = ~v;
            rx_bus.RX_IN = v;
            @(posedge CLK);
            #1;
        end
        rx_bus.RX_IN = 1'b1;
    endtask

    initial begin
        int s1;
        rx_bus.RX_IN    = 1'b1;
        rx_bus.Prescale = PW'(8);
        rx_bus.PAR_EN   = 1'b0;
        rx_bus.PAR_TYP  = PAR_EVEN;
        RST             = 1'b1;
        clearMonitor();
        repeat (3) @(posedge CLK);
        #1;
        checkOutput("rst_pdata", 32'(rx_bus.P_DATA), 32'h00);
        checkOutput("rst_dv",    32'(rx_bus.data_valid), 0);
        checkOutput("rst_pe",    32'(rx_bus.par_err), 0);
        checkOutput("rst_se",    32'(rx_bus.stp_err), 0);
        checkOutput("rst_busy",  32'(rx_bus.busy), 0);
        RST = 1'b0;
        idle(3);

        $display("[TB] frame 0xA5, prescale 8, no parity");
        clearMonitor();
        applyStimulus(8'hA5, 8, 0, 0, 0, 1, 8, -1, -1);
        idle(4);
        checkOutput("t1_dv_count",   32'(dv_count), 1);
        checkOutput("t1_dv_cycle",   32'(dv_cycles[0] - start_cyc), 79);
        checkOutput("t1_pdata",      32'(rx_bus.P_DATA), 32'hA5);
        checkOutput("t1_pe",         32'(pe_count), 0);
        checkOutput("t1_se",         32'(se_count), 0);
        checkOutput("t1_busy_first", 32'(busy_first - start_cyc), 1);
        checkOutput("t1_busy_last",  32'(busy_last - start_cyc), 78);
        checkOutput("t1_busy_cnt",   32'(busy_cnt), 78);

        $display("[TB] frame 0x3C, prescale 16, even parity");
        clearMonitor();
        applyStimulus(8'h3C, 16, 1, PAR_EVEN, 0, 1, 16, -1, -1);
        idle(4);
        checkOutput("t2a_dv_count", 32'(dv_count), 1);
        checkOutput("t2a_dv_cycle", 32'(dv_cycles[0] - start_cyc), 171);
        checkOutput("t2a_pdata",    32'(rx_bus.P_DATA), 32'h3C);
        checkOutput("t2a_pe",       32'(pe_count), 0);

        clearMonitor();
        applyStimulus(8'h3C, 16, 1, PAR_EVEN, 1, 1, 16, -1, -1);
        idle(4);
        checkOutput("t2b_pe_count", 32'(pe_count), 1);
        checkOutput("t2b_pe_cycle", 32'(pe_cycle - start_cyc), 171);
        checkOutput("t2b_dv",       32'(dv_count), 0);
        checkOutput("t2b_pdata",    32'(rx_bus.P_DATA), 32'h3C);

        $display("[TB] frame 0x01, prescale 32, odd parity, stop low");
        clearMonitor();
        applyStimulus(8'h01, 32, 1, PAR_ODD, 0, 0, 19, -1, -1);
        idle(8);
        checkOutput("t3_se_count", 32'(se_count), 1);
        checkOutput("t3_se_cycle", 32'(se_cycle - start_cyc), 339);
        checkOutput("t3_pe",       32'(pe_count), 0);
        checkOutput("t3_dv",       32'(dv_count), 0);
        checkOutput("t3_pdata",    32'(rx_bus.P_DATA), 32'h3C);

        $display("[TB] start glitch and corrupted sample");
        clearMonitor();
        rx_bus.Prescale = PW'(8);
        rx_bus.PAR_EN   = 1'b0;
        start_cyc       = cyc;
        rx_bus.RX_IN    = 1'b0;
        idle(2);
        rx_bus.RX_IN    = 1'b1;
        idle(20);
        checkOutput("t4a_busy_last", 32'(busy_last - start_cyc), 7);
        checkOutput("t4a_busy_cnt",  32'(busy_cnt), 7);
        checkOutput("t4a_dv",        32'(dv_count), 0);
        checkOutput("t4a_pe",        32'(pe_count), 0);
        checkOutput("t4a_se",        32'(se_count), 0);

        clearMonitor();
        applyStimulus(8'h96, 8, 0, 0, 0, 1, 8, 2, -1);
        idle(4);
        checkOutput("t4b_dv",    32'(dv_count), 1);
        checkOutput("t4b_pdata", 32'(rx_bus.P_DATA), 32'h96);

        $display("[TB] back-to-back frames 0x55, 0xAA");
        clearMonitor();
        applyStimulus(8'h55, 8, 0, 0, 0, 1, 7, -1, -1);
        s1 = start_cyc;
        applyStimulus(8'hAA, 8, 0, 0, 0, 1, 8, -1, -1);
        idle(4);
        checkOutput("t5_dv_count", 32'(dv_count), 2);
        checkOutput("t5_data0",    32'(dv_data[0]), 32'h55);
        checkOutput("t5_data1",    32'(dv_data[1]), 32'hAA);
        checkOutput("t5_cycle0",   32'(dv_cycles[0] - s1), 79);
        checkOutput("t5_cycle1",   32'(dv_cycles[1] - s1), 158);

        $display("[TB] reset during data bit 4");
        clearMonitor();
        applyStimulus(8'h7E, 8, 0, 0, 0, 1, 8, -1, 42);
        checkOutput("t6_busy_before", 32'(rx_bus.busy), 1);
        RST = 1'b1;
        idle(1);
        RST = 1'b0;
        checkOutput("t6_busy",  32'(rx_bus.busy), 0);
        checkOutput("t6_dv",    32'(rx_bus.data_valid), 0);
        checkOutput("t6_pe",    32'(rx_bus.par_err), 0);
        checkOutput("t6_se",    32'(rx_bus.stp_err), 0);
        checkOutput("t6_pdata", 32'(rx_bus.P_DATA), 32'h00);
        idle(3);
        checkOutput("t6_no_pulse", 32'(dv_count + pe_count + se_count), 0);
        clearMonitor();
        applyStimulus(8'h7E, 8, 0, 0, 0, 1, 8, -1, -1);
        idle(4);
        checkOutput("t6_dv_count", 32'(dv_count), 1);
        checkOutput("t6_frame",    32'(rx_bus.P_DATA), 32'h7E);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
